// File: rtl/alu_rf_core.sv
// Parametrised ALU with an NREG-entry register file, barrel shifter, NZCV flags and valid/ready handshake.
// Optional signed saturation of add/subtract ops is enabled by defining ALU_SAT_EN.
module alu_rf_core #(
    parameter int WIDTH = 8,
    parameter int NREG  = 4,
    localparam int RW = $clog2(NREG),
    localparam int SW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic             src_sel,
    input  logic [RW-1:0]    rs,
    input  logic [RW-1:0]    rd,
    input  logic             rd_we,
    input  logic [1:0]       shmode,
    input  logic [SW-1:0]    shamt,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] z,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       flags
);

    logic [WIDTH-1:0]        rf [NREG];
    logic [WIDTH-1:0]        m_p0, alu_p0, shf_p0;
    logic [WIDTH:0]          add_p0, sub_am_p0, sub_ma_p0;
    logic [WIDTH:0]          rsh_p0, lsh_p0;
    logic signed [WIDTH:0]   ash_p0;
    logic                    c_p0, v_p0, cf_p0;
    logic                    accept;

    function automatic logic ovf_add(input logic sx, input logic sy, input logic sr);
        return (sx == sy) && (sr != sx);
    endfunction

    // Overflow of x - y: operands of differing sign and result sign differs from x.
    function automatic logic ovf_sub(input logic sx, input logic sy, input logic sr);
        return (sx != sy) && (sr != sx);
    endfunction

`ifdef ALU_SAT_EN
    function automatic logic [WIDTH-1:0] sat_lim(input logic neg);
        return neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    endfunction
`endif

    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign m_p0      = src_sel ? rf[rs] : b;
    assign add_p0    = {1'b0, a} + {1'b0, m_p0};
    assign sub_am_p0 = {1'b0, a} - {1'b0, m_p0};
    assign sub_ma_p0 = {1'b0, m_p0} - {1'b0, a};

    always_comb begin
        alu_p0 = a;
        c_p0   = 1'b0;
        v_p0   = 1'b0;
        case (op)
            3'b000: alu_p0 = a;
            3'b001: alu_p0 = m_p0;
            3'b010: begin
                alu_p0 = add_p0[WIDTH-1:0];
                c_p0   = add_p0[WIDTH];
                v_p0   = ovf_add(a[WIDTH-1], m_p0[WIDTH-1], add_p0[WIDTH-1]);
            end
            3'b011: begin
                alu_p0 = sub_am_p0[WIDTH-1:0];
                c_p0   = sub_am_p0[WIDTH];
                v_p0   = ovf_sub(a[WIDTH-1], m_p0[WIDTH-1], sub_am_p0[WIDTH-1]);
            end
            3'b100: begin
                alu_p0 = sub_ma_p0[WIDTH-1:0];
                c_p0   = sub_ma_p0[WIDTH];
                v_p0   = ovf_sub(m_p0[WIDTH-1], a[WIDTH-1], sub_ma_p0[WIDTH-1]);
            end
            3'b101: alu_p0 = a & m_p0;
            3'b110: alu_p0 = a | m_p0;
            default: alu_p0 = a ^ m_p0;
        endcase
`ifdef ALU_SAT_EN
        // The minuend (or either addend) sign tells which way the result overflowed.
        if (v_p0)
            alu_p0 = sat_lim(op == 3'b100 ? m_p0[WIDTH-1] : a[WIDTH-1]);
`endif
    end

    // Guard bit below (right shifts) or above (left shift) catches the last bit shifted out.
    always_comb begin
        rsh_p0 = {alu_p0, 1'b0} >> shamt;
        lsh_p0 = {1'b0, alu_p0} << shamt;
        ash_p0 = $signed({alu_p0, 1'b0}) >>> shamt;
        shf_p0 = alu_p0;
        cf_p0  = c_p0;
        case (shmode)
            2'b01: shf_p0 = rsh_p0[WIDTH:1];
            2'b10: shf_p0 = lsh_p0[WIDTH-1:0];
            2'b11: shf_p0 = ash_p0[WIDTH:1];
            default: shf_p0 = alu_p0;
        endcase
        if (shamt != '0) begin
            case (shmode)
                2'b01: cf_p0 = rsh_p0[0];
                2'b10: cf_p0 = lsh_p0[WIDTH];
                2'b11: cf_p0 = ash_p0[0];
                default: cf_p0 = c_p0;
            endcase
        end
    end

    // Result / register-file stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z         <= '0;
            flags     <= '0;
            out_valid <= 1'b0;
            for (int i = 0; i < NREG; i++)
                rf[i] <= '0;
        end else if (accept) begin
            z         <= shf_p0;
            flags     <= {shf_p0[WIDTH-1], (shf_p0 == '0), cf_p0, v_p0};
            out_valid <= 1'b1;
            if (rd_we)
                rf[rd] <= shf_p0;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
